// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    // Sequencer states: issue a request, wait for the response, hold the word, stop on fault.
    typedef enum logic [1:0] {
        ST_REQUEST = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    // Fault reasons reported on fault_cause.
    localparam logic [1:0] CAUSE_NONE       = 2'd0;
    localparam logic [1:0] CAUSE_BUS        = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'd2;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [PC_W-1:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_sequencer_pc.sv
// Program counter register with its reset / redirect / increment mux.
module fetch_sequencer_pc
    import fetch_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            pc_inc,
    input  logic            pc_load,
    input  logic [PC_W-1:0] load_pc,
    output logic [PC_W-1:0] pc
);

    // Redirect has priority over sequential advance; the add wraps modulo 2^32.
    always_ff @(posedge clock) begin
        if (clear) begin
            pc <= RESET_PC;
        end else if (pc_load) begin
            pc <= load_pc;
        end else if (pc_inc) begin
            pc <= pc + PC_INC;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: requests one word at a time, holds it for decode, handles redirects and faults.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               mem_ready,
    input  logic               has_fetched,
    input  logic               fetch_error,
    input  logic [INSTR_W-1:0] instruction,
    output logic               should_fetch,
    output logic [PC_W-1:0]    address,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               fault,
    output logic [1:0]         fault_cause,
    output logic [PC_W-1:0]    fault_pc
);

    state_t          state;
    state_t          state_nxt;
    logic            kill;
    logic            kill_nxt;
    logic [PC_W-1:0] pc;
    logic            pc_inc;
    logic            pc_load;
    logic            latch_en;
    logic            fault_set;
    logic [1:0]      cause_nxt;
    logic [PC_W-1:0] fpc_nxt;
    logic            misaligned;
    logic            response;

    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign response   = has_fetched || fetch_error;

    fetch_sequencer_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock   (clock),
        .clear   (clear),
        .pc_inc  (pc_inc),
        .pc_load (pc_load),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    // Outputs decoded purely from registered state so no ready input reaches them combinationally.
    assign should_fetch = (state == ST_REQUEST);
    assign instr_valid  = (state == ST_HOLD);
    assign fault        = (state == ST_FAULT);
    assign address      = pc;

    // State and kill-flag register.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= ST_REQUEST;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            kill  <= kill_nxt;
        end
    end

    // Held instruction and fault record; cleared so that a reset leaves no stale word visible.
    always_ff @(posedge clock) begin
        if (clear) begin
            instr_out   <= '0;
            instr_pc    <= '0;
            fault_cause <= CAUSE_NONE;
            fault_pc    <= '0;
        end else begin
            if (latch_en) begin
                instr_out <= instruction;
                instr_pc  <= pc;
            end
            if (fault_set) begin
                fault_cause <= cause_nxt;
                fault_pc    <= fpc_nxt;
            end
        end
    end

    // Next-state logic: misaligned redirect beats everything, redirect beats instr_ready,
    // and a redirect during WAIT arms kill so the in-flight response is thrown away.
    always_comb begin
        state_nxt = state;
        kill_nxt  = kill;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        latch_en  = 1'b0;
        fault_set = 1'b0;
        cause_nxt = CAUSE_NONE;
        fpc_nxt   = '0;
        case (state)
            ST_REQUEST: begin
                if (misaligned) begin
                    state_nxt = ST_FAULT;
                    fault_set = 1'b1;
                    cause_nxt = CAUSE_MISALIGNED;
                    fpc_nxt   = redirect_pc;
                end else if (redirect_valid) begin
                    pc_load = 1'b1;
                end else if (mem_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (misaligned) begin
                    state_nxt = ST_FAULT;
                    kill_nxt  = 1'b0;
                    fault_set = 1'b1;
                    cause_nxt = CAUSE_MISALIGNED;
                    fpc_nxt   = redirect_pc;
                end else if (kill || redirect_valid) begin
                    pc_load = redirect_valid;
                    if (response) begin
                        state_nxt = ST_REQUEST;
                        kill_nxt  = 1'b0;
                    end else begin
                        kill_nxt = 1'b1;
                    end
                end else if (fetch_error) begin
                    state_nxt = ST_FAULT;
                    fault_set = 1'b1;
                    cause_nxt = CAUSE_BUS;
                    fpc_nxt   = pc;
                end else if (has_fetched) begin
                    state_nxt = ST_HOLD;
                    latch_en  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (misaligned) begin
                    state_nxt = ST_FAULT;
                    fault_set = 1'b1;
                    cause_nxt = CAUSE_MISALIGNED;
                    fpc_nxt   = redirect_pc;
                end else if (redirect_valid) begin
                    state_nxt = ST_REQUEST;
                    pc_load   = 1'b1;
                end else if (instr_ready) begin
                    state_nxt = ST_REQUEST;
                    pc_inc    = 1'b1;
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_REQUEST;
            end
        endcase
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning PC loaded on clear.
REQ-002 Ports: one clock; reset is synchronous and active-high.
- clock  in  1  sole clock, rising edge.
- clear  in  1  synchronous active-high reset.
REQ-003 Ports to and from the Fetch stage and memory controller:
- mem_ready  in  1  memory controller ready.
- has_fetched  in  1  good response from Fetch.
- fetch_error  in  1  error response from Fetch.
- instruction  in  32  fetched word.
- should_fetch  out  1  request fetch.
- address  out  32  fetch address.
REQ-004 Ports to and from decode and execute:
- instr_valid  out  1  held instruction valid.
- instr_ready  in  1  decode accepts.
- instr_out  out  32  held instruction.
- instr_pc  out  32  PC of the held instruction.
- redirect_valid  in  1  branch or jump taken.
- redirect_pc  in  32  new PC.
- fault  out  1  sticky fault flag.
- fault_cause  out  2  fault reason.
- fault_pc  out  32  faulting address.

Function
REQ-005 FSM states SHALL be REQUEST, WAIT, HOLD, FAULT; state register clocked by clock only.
REQ-006 REQUEST: should_fetch=1, address=pc; request accepted when should_fetch & mem_ready; on acceptance SHALL go to WAIT next cycle.
REQ-007 WAIT: should_fetch=0; has_fetched SHALL latch instruction into instr_out, pc into instr_pc, and go to HOLD.
REQ-008 WAIT: fetch_error SHALL go to FAULT with fault_cause=2'd1 and fault_pc=pc.
REQ-009 HOLD: instr_valid=1; instr_out and instr_pc SHALL stay stable until instr_valid & instr_ready.
- On acceptance: pc<=pc+4, go to REQUEST.
- Minimum issue interval is 3 cycles (REQUEST, WAIT, HOLD).
REQ-010 pc arithmetic SHALL be 32-bit modulo; pc 32'hFFFF_FFFC + 4 = 32'h0000_0000, no fault.
REQ-011 Redirect in REQUEST or HOLD:
- pc<=redirect_pc and go to REQUEST.
- Held instruction dropped (instr_valid=0 next cycle).
- In HOLD, redirect SHALL win over a simultaneous instr_ready; no pc+4 applied.
REQ-012 Redirect in WAIT:
- pc<=redirect_pc and kill flag set; remain in WAIT.
- The next response (good or error) is discarded, with no fault, kill cleared, then go to REQUEST.
- Redirect coincident with the response SHALL behave identically.
REQ-013 redirect_pc[1:0]!=0 SHALL go to FAULT with fault_cause=2'd2 and fault_pc=redirect_pc, regardless of state (except FAULT).
REQ-014 FAULT: should_fetch=0, instr_valid=0, fault=1; all inputs including redirect are ignored until clear.
REQ-015 has_fetched or fetch_error outside WAIT SHALL be ignored.
REQ-016 instr_valid SHALL be 1 only in HOLD; should_fetch only in REQUEST.
REQ-017 All outputs SHALL be registered or decoded from state; no combinational path from instr_ready or mem_ready to outputs.

Reset
REQ-018 On clear (mid-transaction included), next cycle SHALL be:
- state=REQUEST, pc=RESET_PC, kill=0.
- instr_valid=0, instr_out=0, instr_pc=0.
- fault=0, fault_cause=0, fault_pc=0.
- should_fetch=1, address=RESET_PC.
REQ-019 A response arriving in the cycle after clear SHALL be ignored (state is REQUEST).

Structure
REQ-020 Shared package SHALL hold:
- state enum.
- fault_cause constants NONE=0, BUS=1, MISALIGNED=2.
- instruction width 32 and PC increment 4.
REQ-021 One sub-module, fetch_sequencer_pc, SHALL hold the PC register and its mux (reset, +4, redirect); remainder flat.

Verification
REQ-022 Stream: RESET_PC=0x100, mem_ready=1, response 1 cycle after accept, instr_ready=1 -> instr_pc 0x100, 0x104, 0x108 with matching instructions, one per 3 cycles.
REQ-023 Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr_out/instr_pc stable, should_fetch=0; after ready, next address=pc+4.
REQ-024 Redirect in WAIT to 0x200, response 0xDEADBEEF returns -> word discarded, next address=0x200, instr_pc=0x200.
REQ-025 fetch_error in WAIT at pc=0x40 -> fault=1, fault_cause=1, fault_pc=0x40, sticky; clear -> address=RESET_PC.
REQ-026 Boundary cases:
- redirect_pc=0x202 -> fault_cause=2, fault_pc=0x202.
- pc=0xFFFFFFFC accepted -> next address 0x0.
- redirect and instr_ready together in HOLD -> redirect_pc used.
